// File: rtl/seq_detect_if.sv
// Serial bit-stream port bundle for the sequence detector: stimulus side drives
// clear/din_valid/din, detector side returns state, dout and the match count.
interface seq_detect_if #(
    parameter int SW        = 2,
    parameter int CNT_WIDTH = 8
) ();
    logic                 clear;
    logic                 din_valid;
    logic                 din;
    logic [SW-1:0]        state;
    logic                 dout;
    logic [CNT_WIDTH-1:0] match_count;

    modport master (
        output clear,
        output din_valid,
        output din,
        input  state,
        input  dout,
        input  match_count
    );

    modport slave (
        input  clear,
        input  din_valid,
        input  din,
        output state,
        output dout,
        output match_count
    );
endinterface

// File: rtl/seq_detect_fsm.sv
// Parametrised Moore detector for a PAT_WIDTH-bit serial pattern, MSB first,
// with optional overlap, valid-gated input and a saturating match counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// 0     | no pattern prefix matched
// k     | the last accepted bits equal the first k pattern bits
// PW    | full pattern matched, dout high
module seq_detect_fsm #(
    parameter int                   PAT_WIDTH = 3,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = 3'b101,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    seq_detect_if.slave bus
);
    localparam int SW = $clog2(PAT_WIDTH + 1);

    // Longest pattern prefix that is a suffix of (first s pattern bits, b).
    function automatic int next_of(int s, bit b);
        int best;
        int len;
        int j;
        bit ok;
        bit sb;
        best = 0;
        len  = s + 1;
        if (s == PAT_WIDTH && !OVERLAP) begin
            best = (b == PATTERN[PAT_WIDTH-1]) ? 1 : 0;
        end else begin
            for (int k = 1; k <= PAT_WIDTH; k++) begin
                if (k <= len) begin
                    ok = 1'b1;
                    for (int i = 0; i < k; i++) begin
                        j = len - k + i;
                        if (j == s) sb = b;
                        else        sb = PATTERN[PAT_WIDTH-1-j];
                        if (sb != PATTERN[PAT_WIDTH-1-i]) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [(PAT_WIDTH+1)*SW-1:0] build_tbl(bit b);
        logic [(PAT_WIDTH+1)*SW-1:0] tbl;
        tbl = '0;
        for (int s = 0; s <= PAT_WIDTH; s++) begin
            tbl[s*SW +: SW] = SW'(next_of(s, b));
        end
        return tbl;
    endfunction

    localparam logic [(PAT_WIDTH+1)*SW-1:0] NXT_ON0 = build_tbl(1'b0);
    localparam logic [(PAT_WIDTH+1)*SW-1:0] NXT_ON1 = build_tbl(1'b1);
    localparam logic [SW-1:0]               S_FULL  = SW'(PAT_WIDTH);

    logic [SW-1:0]        state_q, state_d, nxt;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        nxt     = '0;
        state_d = state_q;
        count_d = count_q;
        for (int s = 0; s <= PAT_WIDTH; s++) begin
            if (state_q == SW'(s)) begin
                nxt = bus.din ? NXT_ON1[s*SW +: SW] : NXT_ON0[s*SW +: SW];
            end
        end
        // clear wins over an accepted bit; that bit is dropped
        if (bus.clear) begin
            state_d = '0;
            count_d = '0;
        end else if (bus.din_valid) begin
            state_d = nxt;
            if (nxt == S_FULL && count_q != {CNT_WIDTH{1'b1}}) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.dout        = (state_q == S_FULL);
    assign bus.match_count = count_q;
endmodule

// File: doc/seq_detect_fsm.md
# seq_detect_fsm

Parametrised Moore sequence-detector FSM, the generalised successor of the fixed 4-state `din`/`state`/`next_state`/`dout` pattern machine. It detects an arbitrary `PAT_WIDTH`-bit pattern on a serial bit stream, with optional overlap and valid-gated input. It registers its own state and keeps a saturating match counter. It sits in the serial-front-end test fabric, between bit-stream stimulus and the checker/statistics logic.

## Interface
- `PAT_WIDTH`, 3, pattern length in bits; legal range 2..16.
- `PATTERN`, 3'b101, pattern to detect; MSB is the first bit received.
- `OVERLAP`, 1, 1 = overlapping matches allowed; 0 = the bit after a match starts a fresh search.
- `CNT_WIDTH`, 8, width of the match counter.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous soft clear of state and counter.
- `din_valid`  in  1  `din` is consumed this cycle when high.
- `din`  in  1  serial data bit.
- `state`  out  SW  current state = number of pattern bits currently matched, 0..PAT_WIDTH; SW = $clog2(PAT_WIDTH+1).
- `dout`  out  1  Moore output, high while `state == PAT_WIDTH`.
- `match_count`  out  CNT_WIDTH  number of matches since reset/clear, saturating.

## Operation
- State s (0..PAT_WIDTH) is the length of the longest pattern prefix matched by the most recent accepted bits.
- Transition on an accepted bit b, from s < PAT_WIDTH: next = the longest prefix of PATTERN that is a suffix of (first s pattern bits followed by b). This is KMP failure logic, computed at elaboration from PATTERN, with no runtime tables.
- From s == PAT_WIDTH with OVERLAP=1: next = the longest prefix of PATTERN (length ≤ PAT_WIDTH) that is a suffix of (PATTERN followed by b).
- From s == PAT_WIDTH with OVERLAP=0: next = the transition from state 0 on b, i.e. 1 if b equals the PATTERN MSB, else 0.
- With defaults (101, overlap) the machine equals the legacy A/B/C/D machine: A=0, B=1, C=2, D=3.
  - 0: b=0→0, b=1→1
  - 1: b=0→2, b=1→1
  - 2: b=0→0, b=1→3
  - 3: b=0→2, b=1→1
- `din_valid` low: state and counter hold, and `din` is ignored.
- match_count increments by 1 on every accepted bit whose next state is PAT_WIDTH. This includes back-to-back matches (overlap) and the case where the state is already PAT_WIDTH.
- match_count saturates at 2^CNT_WIDTH−1 and never wraps.
- Priority: `resetn` low > `clear` high > `din_valid`. A bit presented with `clear` high is discarded.

## Timing
- Reset (resetn low at a rising edge): state=0, dout=0, match_count=0 from the next cycle on.
- Reset mid-pattern discards all partial matches.
- `clear` has the same effect as reset, one edge, and is independent of `din_valid`.
- Latency: a bit accepted at edge N updates `state`, `dout` and `match_count` after edge N. The completing bit therefore raises `dout` in the cycle following its acceptance.
- `dout` is decoded combinationally from the state register only, with no path from `din` or `din_valid`, so the block is glitch-free Moore.
- `dout` stays high while `din_valid` is low after a match. It drops only on the next accepted bit that leaves state PAT_WIDTH.
- Throughput: one bit per cycle, no stall or back-pressure.

## Test plan
- Defaults with `din_valid` = 1 every cycle, stream 1,0,1,0,1 → state 1,2,3,2,3. `dout` is high after bits 3 and 5, and match_count = 2.
- OVERLAP=0, same stream → state 1,2,3,0,1. `dout` is high only after bit 3, and match_count = 1.
- Defaults, stream 1,0 then `din_valid` low for 5 cycles with `din` toggling, then 1 → state holds at 2 through the gap, then reaches 3. `dout` is high and match_count = 1.
- PAT_WIDTH=4, PATTERN=4'b1101, OVERLAP=1, stream 1,1,0,1,1,0,1 → state 1,2,3,4,2,3,4. `dout` is high after bits 4 and 7, and match_count = 2.
- CNT_WIDTH=2, defaults, stream 1,0,1 repeated 5 times, then `clear` for one cycle with `din_valid`=1 and `din`=1 → match_count goes 1,2,3,3,3, then 0. state=0 after the clear and the bit is discarded.
- Defaults, stream 1,0, then `resetn` low for one edge with `din`=1 and `din_valid`=1 → state=0, dout=0, match_count=0. A following 1,0,1 gives dout=1 and match_count=1.
